// File: rtl/sysarray_pkg.sv
// Shared definitions for the systolic array edge blocks: default geometry
// and small elaboration-time helpers.
package sysarray_pkg;

    localparam int DW_DEF    = 32;
    localparam int LANES_DEF = 4;
    localparam int DEPTH_DEF = 8;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // LSB position of lane k in a packed multi-lane bus.
    function automatic int lane_lsb(input int k, input int dw);
        return k * dw;
    endfunction

endpackage

// File: rtl/sysarray_drain_skew_line.sv
// Fixed-length delay chain of reset-clearable registers; STAGES=0 is a wire.
module skew_line #(
    parameter int STAGES = 1,
    parameter int DW     = 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    generate
        if (STAGES == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clock ^ reset_n;
            assign dout           = din;
        end else begin : g_regs
            logic [DW-1:0] stage_q [STAGES];
            logic [DW-1:0] stage_d [STAGES];

            always_comb begin
                stage_d[0] = din;
                for (int i = 1; i < STAGES; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < STAGES; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < STAGES; i++) begin
                        stage_q[i] <= stage_d[i];
                    end
                end
            end

            assign dout = stage_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/sysarray_drain.sv
// Collects the staggered result lanes leaving the array, re-aligns them into
// rows and buffers the rows in a small FIFO behind a valid/ready port.
module sysarray_drain
    import sysarray_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int LANES = LANES_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    input  logic [LANES*DW-1:0]       in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DW-1:0]       out_data,
    output logic                      stall_req,
    output logic                      overflow,
    input  logic                      ovf_clr,
    output logic [clog2(DEPTH):0]     count
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int W  = LANES * DW;

    logic         row_valid;
    logic [W-1:0] row_data;

    // Lane k arrives k cycles late, so it is held back by the remaining
    // LANES-1-k cycles; the last lane is already aligned.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            skew_line #(
                .STAGES (LANES - 1 - gi),
                .DW     (DW)
            ) u_skew (
                .clock   (clock),
                .reset_n (reset_n),
                .din     (in_data[lane_lsb(gi, DW) +: DW]),
                .dout    (row_data[lane_lsb(gi, DW) +: DW])
            );
        end
    endgenerate

    skew_line #(
        .STAGES (LANES - 1),
        .DW     (1)
    ) u_valid_skew (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (in_valid),
        .dout    (row_valid)
    );

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          stall_req_q, stall_req_d;
    logic [W-1:0]  mem_q [DEPTH];

    logic empty, full, pop, push, drop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign pop   = !empty && out_ready;
    // A pop frees the head slot in the same edge, so a full FIFO can still accept.
    assign push  = row_valid && (!full || pop);
    assign drop  = row_valid && full && !pop;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        // Leave room for the rows that may already be inside the skew lines.
        stall_req_d = (DEPTH - int'(count_d)) <= (LANES - 1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            stall_req_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            stall_req_q <= stall_req_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= row_data;
        end
    end

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign stall_req = stall_req_q;
    assign overflow  = overflow_q;
    assign count     = count_q;

endmodule
